// File: rtl/branch_resolve.sv
// Resolves EX-stage branches and jumps, issues one-cycle fetch redirects,
// and maintains a 2-bit saturating-counter BHT with resolution statistics.
module branch_resolve #(
  parameter int BHT_IDX_W = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ex_valid_i,
  input  logic        ex_is_branch_i,
  input  logic        ex_is_jump_i,
  input  logic [2:0]  ex_funct3_i,
  input  logic [31:0] ex_pc_i,
  input  logic [31:0] ex_target_i,
  input  logic        ex_pred_taken_i,
  input  logic        br_less_i,
  input  logic        br_equal_i,
  output logic        br_unsigned_o,
  input  logic [31:0] if_pc_i,
  output logic        if_pred_taken_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic [15:0] br_count_o,
  output logic [15:0] mispred_count_o
);

  localparam int BHT_N = 1 << BHT_IDX_W;

  logic [1:0]           r_bht [BHT_N];
  logic                 r_redirect;
  logic [31:0]          r_redirect_pc;
  logic                 r_shadow;
  logic [15:0]          r_br_count;
  logic [15:0]          r_mispred_count;

  logic                 w_resolved;
  logic                 w_jump;
  logic                 w_branch;
  logic                 w_taken;
  logic                 w_cond_ok;
  logic                 w_mispredict;
  logic [31:0]          w_correct_pc;
  logic [31:0]          w_pc_plus4;
  logic [BHT_IDX_W-1:0] w_ex_idx;
  logic [BHT_IDX_W-1:0] w_if_idx;
  logic                 w_unused_if_pc;

  assign br_unsigned_o = (ex_funct3_i == 3'b110) || (ex_funct3_i == 3'b111);

  always_comb begin
    w_taken   = 1'b0;
    w_cond_ok = 1'b1;
    case (ex_funct3_i)
      3'b000:  w_taken = br_equal_i;
      3'b001:  w_taken = ~br_equal_i;
      3'b100:  w_taken = br_less_i;
      3'b101:  w_taken = ~br_less_i;
      3'b110:  w_taken = br_less_i;
      3'b111:  w_taken = ~br_less_i;
      default: w_cond_ok = 1'b0;
    endcase
  end

  // The EX instruction sitting in a redirect cycle is wrong-path.
  assign w_resolved = ex_valid_i & ~r_shadow;
  assign w_jump     = w_resolved & ex_is_jump_i;
  assign w_branch   = w_resolved & ex_is_branch_i & ~ex_is_jump_i & w_cond_ok;
  assign w_pc_plus4 = ex_pc_i + 32'd4;

  always_comb begin
    w_mispredict = 1'b0;
    w_correct_pc = w_pc_plus4;
    if (w_jump) begin
      w_mispredict = 1'b1;
      w_correct_pc = ex_target_i;
    end else if (w_branch) begin
      w_mispredict = (w_taken != ex_pred_taken_i);
      w_correct_pc = w_taken ? ex_target_i : w_pc_plus4;
    end else begin
      w_mispredict = 1'b0;
    end
  end

  assign w_ex_idx       = ex_pc_i[BHT_IDX_W+1:2];
  assign w_if_idx       = if_pc_i[BHT_IDX_W+1:2];
  assign w_unused_if_pc = ^{if_pc_i[31:BHT_IDX_W+2], if_pc_i[1:0]};

  // Array read sees the pre-update value when IF and EX hit the same entry.
  assign if_pred_taken_o = r_bht[w_if_idx][1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_redirect      <= 1'b0;
      r_redirect_pc   <= 32'd0;
      r_shadow        <= 1'b0;
      r_br_count      <= 16'd0;
      r_mispred_count <= 16'd0;
      for (int i = 0; i < BHT_N; i++) begin
        r_bht[i] <= 2'b01;
      end
    end else begin
      r_redirect <= w_mispredict;
      r_shadow   <= w_mispredict;
      if (w_mispredict) begin
        r_redirect_pc <= w_correct_pc;
        if (r_mispred_count != 16'hFFFF) begin
          r_mispred_count <= r_mispred_count + 16'd1;
        end
      end
      if (w_branch) begin
        if (r_br_count != 16'hFFFF) begin
          r_br_count <= r_br_count + 16'd1;
        end
        if (w_taken && (r_bht[w_ex_idx] != 2'b11)) begin
          r_bht[w_ex_idx] <= r_bht[w_ex_idx] + 2'b01;
        end else if (!w_taken && (r_bht[w_ex_idx] != 2'b00)) begin
          r_bht[w_ex_idx] <= r_bht[w_ex_idx] - 2'b01;
        end
      end
    end
  end

  assign redirect_o      = r_redirect;
  assign redirect_pc_o   = r_redirect_pc;
  assign br_count_o      = r_br_count;
  assign mispred_count_o = r_mispred_count;

endmodule
